fb_access_arbiter: RTL and testbench

//  Shares one single-port synchronous framebuffer RAM (1 access/cycle, 1-cycle read latency)

---
 rtl/fb_access_arbiter.sv | 118 +++++++++++
 tb/tb_fb_access_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_access_arbiter.sv
// Framebuffer RAM arbiter: scan-out reads always win, two writers share leftover cycles
// round-robin, with per-writer sticky starvation detection.
module fb_access_arbiter #(
   parameter int unsigned ADDR_W        = 19,
   parameter int unsigned DATA_W        = 8,
   parameter int unsigned WR_BLANK_ONLY = 0,
   parameter int unsigned STARVE_LIMIT  = 1024
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              blank,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic [DATA_W-1:0] disp_data,
   output logic              disp_valid,
   input  logic              wr0_valid,
   output logic              wr0_ready,
   input  logic [ADDR_W-1:0] wr0_addr,
   input  logic [DATA_W-1:0] wr0_data,
   input  logic              wr1_valid,
   output logic              wr1_ready,
   input  logic [ADDR_W-1:0] wr1_addr,
   input  logic [DATA_W-1:0] wr1_data,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [1:0]        wr_starve
);

   localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

   logic              w_wr_elig;
   logic              w_gnt0;
   logic              w_gnt1;
   logic [1:0]        w_valid;
   logic [1:0]        w_gnt;
   logic [CNT_W-1:0]  w_cnt_nxt [2];
   logic              r_rr;
   logic              r_rd_s1;
   logic              r_disp_valid;
   logic [CNT_W-1:0]  r_cnt [2];

   // Writers see only cycles the display does not claim (and, optionally, only in blanking)
   assign w_wr_elig = !disp_req && ((WR_BLANK_ONLY == 0) || blank);
   assign w_gnt0    = w_wr_elig && wr0_valid && (!wr1_valid || !r_rr);
   assign w_gnt1    = w_wr_elig && wr1_valid && (!wr0_valid ||  r_rr);
   assign wr0_ready = w_gnt0;
   assign wr1_ready = w_gnt1;

   // RAM output data is already registered; gating keeps disp_data at 0 when not valid
   assign disp_valid = r_disp_valid;
   assign disp_data  = r_disp_valid ? ram_rdata : '0;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ram_en       <= 1'b0;
         ram_we       <= 1'b0;
         ram_addr     <= '0;
         ram_wdata    <= '0;
         r_rr         <= 1'b0;
         r_rd_s1      <= 1'b0;
         r_disp_valid <= 1'b0;
      end else begin
         r_rd_s1      <= disp_req;
         r_disp_valid <= r_rd_s1;
         if (disp_req) begin
            ram_en   <= 1'b1;
            ram_we   <= 1'b0;
            ram_addr <= disp_addr;
         end else if (w_gnt0) begin
            ram_en    <= 1'b1;
            ram_we    <= 1'b1;
            ram_addr  <= wr0_addr;
            ram_wdata <= wr0_data;
            r_rr      <= 1'b1;
         end else if (w_gnt1) begin
            ram_en    <= 1'b1;
            ram_we    <= 1'b1;
            ram_addr  <= wr1_addr;
            ram_wdata <= wr1_data;
            r_rr      <= 1'b0;
         end else begin
            ram_en <= 1'b0;
            ram_we <= 1'b0;
         end
      end
   end

   assign w_valid = {wr1_valid, wr0_valid};
   assign w_gnt   = {w_gnt1, w_gnt0};

   // Wait counters count un-granted requesting cycles and saturate at the limit
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         w_cnt_nxt[i] = '0;
         if (w_valid[i] && !w_gnt[i]) begin
            if (r_cnt[i] == CNT_W'(STARVE_LIMIT)) w_cnt_nxt[i] = r_cnt[i];
            else                                  w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt[0]  <= '0;
         r_cnt[1]  <= '0;
         wr_starve <= 2'b00;
      end else begin
         for (int i = 0; i < 2; i++) begin
            r_cnt[i] <= w_cnt_nxt[i];
            if (w_cnt_nxt[i] == CNT_W'(STARVE_LIMIT)) wr_starve[i] <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Scoreboard bench for fb_access_arbiter with a behavioural single-port RAM model.
module tb_fb_access_arbiter;

   localparam int unsigned AW = 19;
   localparam int unsigned DW = 8;

   typedef struct { int cyc; logic [DW-1:0] d; } rd_t;
   typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;

   logic          clock = 1'b0;
   logic          reset_n, blank, disp_req;
   logic [AW-1:0] disp_addr;
   logic [DW-1:0] disp_data;
   logic          disp_valid;
   logic          wr0_valid, wr0_ready, wr1_valid, wr1_ready;
   logic [AW-1:0] wr0_addr, wr1_addr;
   logic [DW-1:0] wr0_data, wr1_data;
   logic          ram_en, ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata, ram_rdata;
   logic [1:0]    wr_starve;

   logic          b_wr0_valid, b_wr1_valid, b_wr0_ready, b_wr1_ready;
   logic [DW-1:0] b_disp_data, b_rdata, b_ram_wdata;
   logic          b_disp_valid, b_ram_en, b_ram_we;
   logic [AW-1:0] b_ram_addr;
   logic [1:0]    b_wr_starve;

   logic [DW-1:0] mem [int];
   rd_t rd_q[$];
   wr_t wr_q[$];
   rd_t m_rd;
   wr_t m_wr;
   int  total = 0;
   int  bad   = 0;
   int  cyc   = 0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   fb_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WR_BLANK_ONLY(0), .STARVE_LIMIT(8)) dut (
      .clock(clock), .reset_n(reset_n), .blank(blank), .disp_req(disp_req),
      .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
      .wr0_valid(wr0_valid), .wr0_ready(wr0_ready), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
      .wr1_valid(wr1_valid), .wr1_ready(wr1_ready), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .wr_starve(wr_starve));

   // Blank-gated instance: only its writer-0 handshake is observed
   fb_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WR_BLANK_ONLY(1), .STARVE_LIMIT(8)) dut_b (
      .clock(clock), .reset_n(reset_n), .blank(blank), .disp_req(disp_req),
      .disp_addr(disp_addr), .disp_data(b_disp_data), .disp_valid(b_disp_valid),
      .wr0_valid(b_wr0_valid), .wr0_ready(b_wr0_ready), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
      .wr1_valid(b_wr1_valid), .wr1_ready(b_wr1_ready), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
      .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata),
      .ram_rdata(b_rdata), .wr_starve(b_wr_starve));

   function automatic logic [DW-1:0] init_px(int a);
      return DW'(a * 7 + 3);
   endfunction

   function automatic logic [DW-1:0] memv(int a);
      return mem.exists(a) ? mem[a] : init_px(a);
   endfunction

   always @(posedge clock) begin
      if (ram_en) begin
         if (ram_we) mem[int'(ram_addr)] = ram_wdata;
         else        ram_rdata <= memv(int'(ram_addr));
      end
   end

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic exp_rd(int c, logic [DW-1:0] d);
      rd_t e;
      e.cyc = c;
      e.d   = d;
      rd_q.push_back(e);
   endtask

   task automatic exp_wr(logic [AW-1:0] a, logic [DW-1:0] d);
      wr_t e;
      e.a = a;
      e.d = d;
      wr_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_all_zero(string name);
      chk(name, 64'({disp_data, disp_valid, wr0_ready, wr1_ready, ram_en, ram_we,
                     ram_addr, ram_wdata, wr_starve}), 64'd0);
   endtask

   // Monitor: every observed read result and RAM write is matched against the scoreboard
   always @(negedge clock) begin
      if (disp_valid) begin
         if (rd_q.size() == 0) chk("stale_disp_valid", 64'd1, 64'd0);
         else begin
            m_rd = rd_q.pop_front();
            chk("disp_cycle", 64'(cyc), 64'(m_rd.cyc));
            chk("disp_data", 64'(disp_data), 64'(m_rd.d));
         end
      end
      if (ram_en && ram_we) begin
         if (wr_q.size() == 0) chk("unexpected_write", 64'd1, 64'd0);
         else begin
            m_wr = wr_q.pop_front();
            chk("wr_addr", 64'(ram_addr), 64'(m_wr.a));
            chk("wr_data", 64'(ram_wdata), 64'(m_wr.d));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench exceeded time limit at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int  idx0, idx1;
      logic g0, g1;
      reset_n = 1'b0; blank = 1'b0; disp_req = 1'b0; disp_addr = '0;
      wr0_valid = 1'b0; wr0_addr = '0; wr0_data = '0;
      wr1_valid = 1'b0; wr1_addr = '0; wr1_data = '0;
      b_wr0_valid = 1'b0; b_wr1_valid = 1'b0; b_rdata = '0;

      repeat (2) @(negedge clock);
      chk_all_zero("reset_state");
      tick();
      reset_n = 1'b1;
      tick();

      // Display owns every cycle; both writers wait
      wr0_valid = 1'b1; wr0_addr = AW'(32'h5000); wr0_data = 8'h11;
      wr1_valid = 1'b1; wr1_addr = AW'(32'h5001); wr1_data = 8'h22;
      for (int i = 0; i < 640; i++) begin
         disp_req  = 1'b1;
         disp_addr = AW'(i);
         exp_rd(cyc + 2, init_px(i));
         @(negedge clock);
         chk("t1_no_ready", 64'({wr0_ready, wr1_ready}), 64'd0);
         tick();
      end
      disp_req = 1'b0; wr0_valid = 1'b0; wr1_valid = 1'b0;
      chk("t1_both_starved", 64'(wr_starve), 64'd3);
      repeat (3) tick();

      // Round-robin alternation starting from writer 0
      for (int i = 0; i < 4; i++) begin
         exp_wr(AW'(32'h2000 + i), DW'(8'h10 + i));
         exp_wr(AW'(32'h3000 + i), DW'(8'h80 + i));
      end
      idx0 = 0; idx1 = 0;
      for (int c = 0; c < 40 && (idx0 < 4 || idx1 < 4); c++) begin
         wr0_valid = (idx0 < 4); wr0_addr = AW'(32'h2000 + idx0); wr0_data = DW'(8'h10 + idx0);
         wr1_valid = (idx1 < 4); wr1_addr = AW'(32'h3000 + idx1); wr1_data = DW'(8'h80 + idx1);
         @(negedge clock);
         chk("t2_one_ready", 64'(2'(wr0_ready) + 2'(wr1_ready)), 64'd1);
         g0 = wr0_valid && wr0_ready;
         g1 = wr1_valid && wr1_ready;
         tick();
         if (g0) idx0++;
         if (g1) idx1++;
      end
      chk("t2_done", 64'({idx0 == 4, idx1 == 4}), 64'd3);
      wr0_valid = 1'b0; wr1_valid = 1'b0;
      repeat (3) tick();

      // Write then immediate read of the same address
      wr0_valid = 1'b1; wr0_addr = AW'(32'h1000); wr0_data = 8'hA5;
      exp_wr(AW'(32'h1000), 8'hA5);
      @(negedge clock);
      chk("t3_ready", 64'(wr0_ready), 64'd1);
      tick();
      wr0_valid = 1'b0;
      disp_req  = 1'b1;
      disp_addr = AW'(32'h1000);
      exp_rd(cyc + 2, 8'hA5);
      tick();
      disp_req = 1'b0;
      repeat (4) tick();

      // Blank-only writer gating
      blank = 1'b0;
      b_wr0_valid = 1'b1; wr0_addr = AW'(32'h6000); wr0_data = 8'h33;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk("t4_blocked", 64'(b_wr0_ready), 64'd0);
         tick();
      end
      blank = 1'b1;
      @(negedge clock);
      chk("t4_blank_ready", 64'(b_wr0_ready), 64'd1);
      tick();
      b_wr0_valid = 1'b0; blank = 1'b0;
      repeat (2) tick();
      chk("queues_empty_mid", 64'(rd_q.size() + wr_q.size()), 64'd0);

      // Reset mid-stream drops in-flight reads
      disp_req = 1'b1; disp_addr = AW'(5);
      tick();
      disp_addr = AW'(6);
      #2;
      reset_n = 1'b0;
      #1;
      chk_all_zero("t6_reset_async");
      disp_req = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         chk("t6_no_stale", 64'(disp_valid), 64'd0);
         tick();
      end

      // Writer 1 starves behind the display for exactly the limit
      wr1_valid = 1'b1; wr1_addr = AW'(32'h4000); wr1_data = 8'h5C;
      for (int i = 0; i < 8; i++) begin
         disp_req  = 1'b1;
         disp_addr = '0;
         exp_rd(cyc + 2, init_px(0));
         @(negedge clock);
         chk("t5_starve_pre", 64'(wr_starve), 64'd0);
         tick();
      end
      disp_req = 1'b0;
      exp_wr(AW'(32'h4000), 8'h5C);
      @(negedge clock);
      chk("t5_starve_set", 64'(wr_starve), 64'd2);
      chk("t5_ready", 64'(wr1_ready), 64'd1);
      tick();
      wr1_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk("t5_sticky", 64'(wr_starve), 64'd2);
         tick();
      end

      for (int i = 0; i < 4; i++) begin
         chk("mem_w0", 64'(memv(32'h2000 + i)), 64'(8'h10 + i));
         chk("mem_w1", 64'(memv(32'h3000 + i)), 64'(8'h80 + i));
      end
      chk("mem_t3", 64'(memv(32'h1000)), 64'hA5);
      chk("mem_t5", 64'(memv(32'h4000)), 64'h5C);
      chk("queues_empty_end", 64'(rd_q.size() + wr_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
